// File: rtl/buffer_share_arbiter_if.sv
// Handshake and buffer-side signal bundle for buffer_share_arbiter.
// The arbiter uses the slave modport; the request/consumer side uses master.
// With ARB_STATS_EN defined, the bundle also carries the grant statistics counters.
interface buffer_share_arbiter_if #(
    parameter int DataWidth = 64
);
    logic                 Req0Valid;
    logic [DataWidth-1:0] Req0Data;
    logic                 Req0Ready;
    logic                 Req1Valid;
    logic [DataWidth-1:0] Req1Data;
    logic                 Req1Ready;
    logic                 Flush;
    logic [DataWidth-1:0] BufWData;
    logic                 BufWInc;
    logic                 BufRInc;
    logic                 BufJump;
    logic                 OutTag;
    logic                 OutTagValid;
    logic                 HeldValid;
`ifdef ARB_STATS_EN
    logic [31:0]          Grant0Cnt;
    logic [31:0]          Grant1Cnt;
    logic [31:0]          ForceCnt;
`endif

    modport slave (
        input  Req0Valid, Req0Data, Req1Valid, Req1Data, Flush, BufRInc,
        output Req0Ready, Req1Ready, BufWData, BufWInc, BufJump,
               OutTag, OutTagValid, HeldValid
`ifdef ARB_STATS_EN
        , output Grant0Cnt, Grant1Cnt, ForceCnt
`endif
    );

    modport master (
        output Req0Valid, Req0Data, Req1Valid, Req1Data, Flush, BufRInc,
        input  Req0Ready, Req1Ready, BufWData, BufWInc, BufJump,
               OutTag, OutTagValid, HeldValid
`ifdef ARB_STATS_EN
        , input Grant0Cnt, Grant1Cnt, ForceCnt
`endif
    );
endinterface

// File: rtl/buffer_share_arbiter.sv
// buffer_share_arbiter: shares one single-entry pipelined data buffer between
// the fetch side (Req0) and the load/store side (Req1). Req1 has fixed
// priority; Req0 is forced through after StarveLimit consecutive losses.
// The arbiter mirrors the buffer's held-entry flag so it never overwrites a
// held word, and tags each word with its source for the consumer.
// Optional feature macro: ARB_STATS_EN (grant/force statistics counters).
module buffer_share_arbiter #(
    parameter int DataWidth   = 64,
    parameter int StarveLimit = 8
) (
    input logic                    Clk,
    input logic                    Rst,
    buffer_share_arbiter_if.slave  bus
);
    localparam logic [7:0] StarveMax = 8'(StarveLimit);

    logic       held_valid_q, held_valid_d;
    logic       held_tag_q, held_tag_d;
    logic       out_tag_q, out_tag_d;
    logic       out_tag_valid_q, out_tag_valid_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;

    logic       can_wr_s;
    logic       starved_s;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       winc_s;

    // Grant decision: writes only into an empty held slot and never during a flush.
    always_comb begin
        can_wr_s  = ~held_valid_q & ~bus.Flush;
        starved_s = (starve_cnt_q == StarveMax);
        gnt0_s    = can_wr_s & bus.Req0Valid & (~bus.Req1Valid | starved_s);
        gnt1_s    = can_wr_s & bus.Req1Valid & ~gnt0_s;
        winc_s    = gnt0_s | gnt1_s;
    end

    assign bus.Req0Ready   = gnt0_s;
    assign bus.Req1Ready   = gnt1_s;
    assign bus.BufWInc     = winc_s;
    assign bus.BufJump     = bus.Flush;
    assign bus.OutTag      = out_tag_q;
    assign bus.OutTagValid = out_tag_valid_q;
    assign bus.HeldValid   = held_valid_q;

    // Write data mux: granted word, zero when nothing is written.
    always_comb begin
        if (gnt0_s) begin
            bus.BufWData = bus.Req0Data;
        end else if (gnt1_s) begin
            bus.BufWData = bus.Req1Data;
        end else begin
            bus.BufWData = '0;
        end
    end

    // Next-state for the buffer occupancy mirror and Req0 starvation counter.
    always_comb begin
        held_valid_d    = held_valid_q;
        held_tag_d      = held_tag_q;
        out_tag_d       = out_tag_q;
        out_tag_valid_d = out_tag_valid_q;

        if (!bus.Req0Valid || gnt0_s) begin
            starve_cnt_d = 8'd0;
        end else if (can_wr_s && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        if (bus.Flush) begin
            held_valid_d    = 1'b0;
            held_tag_d      = 1'b0;
            out_tag_d       = 1'b0;
            out_tag_valid_d = 1'b0;
        end else begin
            case ({winc_s, bus.BufRInc})
                2'b11: begin
                    // Empty buffer bypass: word goes straight to the output stage.
                    out_tag_d       = gnt1_s;
                    out_tag_valid_d = 1'b1;
                    held_valid_d    = 1'b0;
                end
                2'b10: begin
                    held_tag_d   = gnt1_s;
                    held_valid_d = 1'b1;
                end
                2'b01: begin
                    // With nothing held the buffer presents stale data, so the tag goes invalid.
                    out_tag_d       = held_tag_q;
                    out_tag_valid_d = held_valid_q;
                    held_valid_d    = 1'b0;
                end
                2'b00: begin
                    held_valid_d = held_valid_q;
                end
                default: begin
                    held_valid_d = held_valid_q;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            held_valid_q    <= 1'b0;
            held_tag_q      <= 1'b0;
            out_tag_q       <= 1'b0;
            out_tag_valid_q <= 1'b0;
            starve_cnt_q    <= 8'd0;
        end else begin
            held_valid_q    <= held_valid_d;
            held_tag_q      <= held_tag_d;
            out_tag_q       <= out_tag_d;
            out_tag_valid_q <= out_tag_valid_d;
            starve_cnt_q    <= starve_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] grant0_cnt_q, grant1_cnt_q, force_cnt_q;
    logic        forced_s;

    assign forced_s      = gnt0_s & bus.Req1Valid;
    assign bus.Grant0Cnt = grant0_cnt_q;
    assign bus.Grant1Cnt = grant1_cnt_q;
    assign bus.ForceCnt  = force_cnt_q;

    // Free-running grant statistics; they survive Flush and wrap naturally.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            grant0_cnt_q <= 32'd0;
            grant1_cnt_q <= 32'd0;
            force_cnt_q  <= 32'd0;
        end else begin
            grant0_cnt_q <= grant0_cnt_q + {31'd0, gnt0_s};
            grant1_cnt_q <= grant1_cnt_q + {31'd0, gnt1_s};
            force_cnt_q  <= force_cnt_q + {31'd0, forced_s};
        end
    end
`endif
endmodule

// File: tb/tb_buffer_share_arbiter.sv
// Self-checking bench for buffer_share_arbiter: a queue-based model of the
// shared buffer is checked every cycle, plus hand-computed directed checks.
module tb_buffer_share_arbiter;
    localparam int DW    = 64;
    localparam int LIMIT = 8;

    logic Clk;
    logic Rst;
    int   errors;
    int   checks;

    buffer_share_arbiter_if #(.DataWidth(DW)) bus ();

    buffer_share_arbiter #(.DataWidth(DW), .StarveLimit(LIMIT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model state: tags of words sitting in the buffer's held slot, the tag
    // on the buffer output, and consecutive Req0 losses.
    bit   held_q[$];
    bit   m_out_tag;
    bit   m_out_vld;
    int   loss;
    longint unsigned m_g0, m_g1, m_force;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        held_q.delete();
        m_out_tag = 1'b0;
        m_out_vld = 1'b0;
        loss      = 0;
        m_g0      = 0;
        m_g1      = 0;
        m_force   = 0;
    endtask

    task automatic idle();
        bus.Req0Valid = 1'b0;
        bus.Req1Valid = 1'b0;
        bus.Req0Data  = 64'd0;
        bus.Req1Data  = 64'd0;
        bus.BufRInc   = 1'b0;
        bus.Flush     = 1'b0;
    endtask

    // One clock: compare DUT with the model on the falling edge, advance the
    // model, then return just after the rising edge.
    task automatic cyc();
        bit          can_wr, starved, g0, g1;
        logic [63:0] wd;
        @(negedge Clk);
        if (!Rst) begin
            mdl_reset();
        end else begin
            can_wr  = (held_q.size() == 0) && !bus.Flush;
            starved = (loss == LIMIT);
            g0 = can_wr && bus.Req0Valid && (!bus.Req1Valid || starved);
            g1 = can_wr && bus.Req1Valid && !g0;
            wd = g0 ? bus.Req0Data : (g1 ? bus.Req1Data : 64'd0);
            chk("m_Req0Ready", {63'd0, bus.Req0Ready}, {63'd0, g0});
            chk("m_Req1Ready", {63'd0, bus.Req1Ready}, {63'd0, g1});
            chk("m_BufWInc", {63'd0, bus.BufWInc}, {63'd0, g0 | g1});
            chk("m_BufWData", bus.BufWData, wd);
            chk("m_BufJump", {63'd0, bus.BufJump}, {63'd0, bus.Flush});
            chk("m_HeldValid", {63'd0, bus.HeldValid}, {63'd0, held_q.size() != 0});
            chk("m_OutTagValid", {63'd0, bus.OutTagValid}, {63'd0, m_out_vld});
            if (m_out_vld) chk("m_OutTag", {63'd0, bus.OutTag}, {63'd0, m_out_tag});
`ifdef ARB_STATS_EN
            chk("m_Grant0Cnt", {32'd0, bus.Grant0Cnt}, {32'd0, m_g0[31:0]});
            chk("m_Grant1Cnt", {32'd0, bus.Grant1Cnt}, {32'd0, m_g1[31:0]});
            chk("m_ForceCnt", {32'd0, bus.ForceCnt}, {32'd0, m_force[31:0]});
`endif
            if (g0) m_g0++;
            if (g1) m_g1++;
            if (g0 && bus.Req1Valid) m_force++;
            if (!bus.Req0Valid || g0) loss = 0;
            else if (can_wr && loss < LIMIT) loss++;
            if (bus.Flush) begin
                held_q.delete();
                m_out_vld = 1'b0;
            end else if (bus.BufRInc) begin
                if (g0 || g1) begin
                    m_out_tag = g1;
                    m_out_vld = 1'b1;
                end else if (held_q.size() > 0) begin
                    m_out_tag = held_q.pop_front();
                    m_out_vld = 1'b1;
                end else begin
                    m_out_vld = 1'b0;
                end
            end else if (g0 || g1) begin
                held_q.push_back(g1);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mdl_reset();
        idle();
        Rst = 1'b0;
        #3;
        chk("rst_HeldValid", {63'd0, bus.HeldValid}, 64'd0);
        chk("rst_OutTagValid", {63'd0, bus.OutTagValid}, 64'd0);
        chk("rst_OutTag", {63'd0, bus.OutTag}, 64'd0);
        chk("rst_Req0Ready", {63'd0, bus.Req0Ready}, 64'd0);
        chk("rst_BufWInc", {63'd0, bus.BufWInc}, 64'd0);
        chk("rst_BufJump", {63'd0, bus.BufJump}, 64'd0);
        #9;
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        // Req0 write with simultaneous read: one-cycle pass-through.
        bus.Req0Valid = 1'b1;
        bus.Req0Data  = 64'h11;
        bus.BufRInc   = 1'b1;
        #1;
        chk("t1_Req0Ready", {63'd0, bus.Req0Ready}, 64'd1);
        chk("t1_BufWInc", {63'd0, bus.BufWInc}, 64'd1);
        chk("t1_BufWData", bus.BufWData, 64'h11);
        cyc();
        chk("t1_OutTag", {63'd0, bus.OutTag}, 64'd0);
        chk("t1_OutTagValid", {63'd0, bus.OutTagValid}, 64'd1);
        chk("t1_HeldValid", {63'd0, bus.HeldValid}, 64'd0);
        idle();

        // Req1 write without read: held, blocks the next write even with a read.
        bus.Req1Valid = 1'b1;
        bus.Req1Data  = 64'h22;
        #1;
        chk("t2_Req1Ready", {63'd0, bus.Req1Ready}, 64'd1);
        cyc();
        chk("t2_HeldValid", {63'd0, bus.HeldValid}, 64'd1);
        bus.BufRInc = 1'b1;
        #1;
        chk("t2_Req1Ready_blocked", {63'd0, bus.Req1Ready}, 64'd0);
        chk("t2_BufWInc_blocked", {63'd0, bus.BufWInc}, 64'd0);
        cyc();
        chk("t2_OutTag", {63'd0, bus.OutTag}, 64'd1);
        chk("t2_OutTagValid", {63'd0, bus.OutTagValid}, 64'd1);
        chk("t2_HeldValid_after", {63'd0, bus.HeldValid}, 64'd0);
        idle();
        cyc();

        // Both requesters continuously valid: 8 Req1 grants then a forced Req0.
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b1;
        bus.Req0Data  = 64'hA0;
        bus.Req1Data  = 64'hB1;
        bus.BufRInc   = 1'b1;
        for (int i = 0; i < 27; i++) begin
            #1;
            chk("t3_Req0Ready", {63'd0, bus.Req0Ready}, (i % 9 == 8) ? 64'd1 : 64'd0);
            chk("t3_Req1Ready", {63'd0, bus.Req1Ready}, (i % 9 == 8) ? 64'd0 : 64'd1);
            cyc();
        end
        idle();

        // Read with nothing held and nothing written: output tag goes invalid.
        bus.BufRInc = 1'b1;
        #1;
        chk("t5_BufWInc", {63'd0, bus.BufWInc}, 64'd0);
        cyc();
        chk("t5_OutTagValid", {63'd0, bus.OutTagValid}, 64'd0);
        chk("t5_HeldValid", {63'd0, bus.HeldValid}, 64'd0);

        // Fill output and held slot, then flush with a pending Req1.
        bus.Req1Valid = 1'b1;
        bus.Req1Data  = 64'h33;
        cyc();
        bus.BufRInc = 1'b0;
        cyc();
        bus.Flush   = 1'b1;
        bus.BufRInc = 1'b1;
        #1;
        chk("t4_BufJump", {63'd0, bus.BufJump}, 64'd1);
        chk("t4_Req1Ready", {63'd0, bus.Req1Ready}, 64'd0);
        chk("t4_BufWInc", {63'd0, bus.BufWInc}, 64'd0);
        cyc();
        chk("t4_HeldValid", {63'd0, bus.HeldValid}, 64'd0);
        chk("t4_OutTagValid", {63'd0, bus.OutTagValid}, 64'd0);
        idle();

        // Mixed traffic checked against the model only.
        for (int i = 0; i < 120; i++) begin
            bus.Req0Valid = 1'($urandom_range(0, 1));
            bus.Req1Valid = 1'($urandom_range(0, 1));
            bus.Req0Data  = {$urandom, $urandom};
            bus.Req1Data  = {$urandom, $urandom};
            bus.BufRInc   = ($urandom_range(0, 3) != 0);
            bus.Flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();

        // Reset mid-transfer with a held word and a part-counted starvation run.
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b1;
        bus.BufRInc   = 1'b1;
        cyc();
        bus.BufRInc = 1'b0;
        cyc();
        idle();
        #2;
        Rst = 1'b0;
        #1;
        chk("t6_HeldValid", {63'd0, bus.HeldValid}, 64'd0);
        chk("t6_OutTagValid", {63'd0, bus.OutTagValid}, 64'd0);
`ifdef ARB_STATS_EN
        chk("t6_Grant0Cnt", {32'd0, bus.Grant0Cnt}, 64'd0);
        chk("t6_Grant1Cnt", {32'd0, bus.Grant1Cnt}, 64'd0);
        chk("t6_ForceCnt", {32'd0, bus.ForceCnt}, 64'd0);
`endif
        cyc();
        Rst = 1'b1;
        cyc();

        // Starvation count restarted from zero: Req0 forced on the 9th cycle again.
        bus.Req0Valid = 1'b1;
        bus.Req1Valid = 1'b1;
        bus.BufRInc   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t6_Req0Ready", {63'd0, bus.Req0Ready}, (i == 8) ? 64'd1 : 64'd0);
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/buffer_share_arbiter.md
# buffer_share_arbiter

Arbitrates two producers (Req0 = fetch side, Req1 = load/store side) onto one shared single-entry pipeline data buffer. Drives the buffer's write port (BufWData/BufWInc) and flush (BufJump), and mirrors the buffer's occupancy so it never overwrites a held entry. Tags every buffered word with its source so the consumer can route results. Sits between the two request sources and the pipelined-mode buffer instance.

## Interface
- DataWidth, 64, width of request data and BufWData
- StarveLimit, 8, consecutive Req0 losses while Req0Valid=1 before Req0 is forced; range 1..255
- Clk  in  1  clock
- Rst  in  1  reset, asynchronous, active-low
- Req0Valid  in  1  Req0 has a word
- Req0Data  in  DataWidth  Req0 word
- Req0Ready  out  1  Req0 word accepted this cycle when Req0Valid=1
- Req1Valid / Req1Data / Req1Ready  same as Req0
- Flush  in  1  discard all buffered state
- BufWData  out  DataWidth  granted word
- BufWInc  out  1  buffer write strobe
- BufRInc  in  1  consumer read strobe, same signal driven to the buffer
- BufJump  out  1  buffer flush
- OutTag  out  1  source of word on buffer RData (0=Req0, 1=Req1)
- OutTagValid  out  1  buffer RData holds a live word
- HeldValid  out  1  mirror of buffer held-entry flag

## Operation
- Internal state: HeldValid, HeldTag, OutTag, OutTagValid, StarveCnt (8 bit).
- Write allowed (CanWr) only when HeldValid=0 and Flush=0. Never write while HeldValid=1, even with BufRInc=1 (buffer would drop the held word).
- Grant when CanWr: Req1 has fixed priority; Req0 wins if Req1Valid=0 or StarveCnt==StarveLimit.
- ReqXReady = CanWr & grant-to-X; combinational from valids/state. BufWInc = Req0Ready&Req0Valid | Req1Ready&Req1Valid; BufWData = granted data, 0 when BufWInc=0.
- StarveCnt: +1 when Req0Valid=1, Req0 not granted, CanWr=1, saturates at StarveLimit; cleared on Req0 grant or Req0Valid=0.
- Mirror update on {BufWInc,BufRInc}:
  - 11: OutTag<=grant, OutTagValid<=1, HeldValid<=0.
  - 10: HeldTag<=grant, HeldValid<=1.
  - 01: OutTag<=HeldTag, OutTagValid<=HeldValid, HeldValid<=0.
  - 00: hold.
- BufRInc with HeldValid=0 and BufWInc=0: OutTagValid<=0 (buffer outputs stale data).
- Flush: BufJump=Flush (combinational); both Ready=0; next edge clears HeldValid, OutTagValid, OutTag, HeldTag; StarveCnt kept.

## Timing
- Reset values: HeldValid=0, OutTagValid=0, OutTag=0, StarveCnt=0; Ready/BufWInc/BufJump=0 while inputs idle.
- Ready/BufWInc/BufJump: zero-cycle paths, no dependency on BufWFull (unused, avoids loop through buffer pipeline bypass).
- Write+read same cycle with empty buffer: word and tag visible on RData/OutTag next cycle (1-cycle latency).
- Write without read: word held; read one or more cycles later moves it out; next write accepted the cycle after that read.
- Flush dominates writes and reads in the same cycle.
- Reset mid-transfer: all state cleared asynchronously; no partial write.

## Configuration
- ARB_STATS_EN defined: adds 32-bit outputs Grant0Cnt, Grant1Cnt, ForceCnt (forced Req0 grants), reset 0, wrap at 2^32, not cleared by Flush.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, Req0Valid=1 Data=0x11, BufRInc=1 -> Req0Ready=1, BufWInc=1, BufWData=0x11; next cycle OutTag=0, OutTagValid=1, HeldValid=0.
- Req1Valid=1 Data=0x22, BufRInc=0 -> write, HeldValid=1; next cycle Req1Ready=0 despite BufRInc=1; after that read OutTag=1, HeldValid=0.
- Both valid continuously, BufRInc=1 every cycle, StarveLimit=8 -> Req1 granted 8 cycles, Req0 granted 9th, pattern repeats.
- HeldValid=1, Flush=1 with Req1Valid=1 -> BufJump=1, Req1Ready=0, BufWInc=0; next cycle HeldValid=0, OutTagValid=0.
- BufRInc=1 on empty buffer -> OutTagValid=0, no write.
- Rst asserted with HeldValid=1 -> HeldValid, OutTagValid, StarveCnt immediately 0; with ARB_STATS_EN, Grant0Cnt/Grant1Cnt/ForceCnt=0.
